// File: rtl/top.sv
// rtl/top.sv - rotary-encoder demo: synchronisers, glitch filter, quadrature step decoder, LED ring
// A rising edge of the filtered A channel makes one step; the filtered B level at that edge sets the direction.
module top #(
  parameter int          FILTER_CYCLES = 0,
  parameter logic [7:0]  LIGHT_RESET   = 8'h01
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rotA,
  input  logic       rotB,
  output logic [7:0] light
);

  localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  // Channel vectors are packed {B, A}.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] sync_vld;
  logic [1:0] filt;
  logic       a_prev;
  logic       arm;
  logic       a_rise;

  always_ff @(posedge clk) begin
    if (nrst) begin
      sync1    <= 2'b00;
      sync2    <= 2'b00;
      sync_vld <= 2'b00;
    end else begin
      sync1    <= {rotB, rotA};
      sync2    <= sync1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  genvar ch;
  generate
    for (ch = 0; ch < 2; ch++) begin : g_chan
      if (FILTER_CYCLES == 0) begin : g_bypass
        assign filt[ch] = sync2[ch];
      end else begin : g_filter
        logic [CNT_W-1:0] cnt;
        logic             level;

        // A level is accepted only after FILTER_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clk) begin
          if (nrst) begin
            cnt   <= '0;
            level <= 1'b0;
          end else if (sync2[ch] == level) begin
            cnt <= '0;
          end else if (cnt == CNT_W'(FILTER_CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync2[ch];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        assign filt[ch] = level;
      end
    end
  endgenerate

  // The reset-zeroed synchroniser does not count as seeing A low; arm waits for a real low sample.
  always_ff @(posedge clk) begin
    if (nrst) begin
      a_prev <= 1'b0;
      arm    <= 1'b0;
    end else begin
      a_prev <= filt[0];
      if (sync_vld[1] && !sync2[0] && !filt[0]) begin
        arm <= 1'b1;
      end
    end
  end

  assign a_rise = filt[0] & ~a_prev & arm;

  always_ff @(posedge clk) begin
    if (nrst) begin
      light <= LIGHT_RESET;
    end else if (a_rise) begin
      if (filt[1]) begin
        light <= {light[6:0], light[7]};
      end else begin
        light <= {light[0], light[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - directed bench for the rotary-encoder top, unfiltered and FILTER_CYCLES=3 builds
module tb_top;

  logic       clk;
  logic       r0, a0, b0;
  logic       r3, a3, b3;
  logic [7:0] light0, light3;
  int         n_tests;
  int         n_fail;

  top #(.FILTER_CYCLES(0), .LIGHT_RESET(8'h01)) dut0 (
    .clk(clk), .nrst(r0), .rotA(a0), .rotB(b0), .light(light0)
  );

  top #(.FILTER_CYCLES(3), .LIGHT_RESET(8'h01)) dut3 (
    .clk(clk), .nrst(r3), .rotA(a3), .rotB(b3), .light(light3)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic ccw0();
    b0 = 1'b1; tick();
    a0 = 1'b1; tick();
    b0 = 1'b0; tick();
    a0 = 1'b0; tick();
    tick(2);
  endtask

  task automatic cw0();
    a0 = 1'b1; tick();
    b0 = 1'b1; tick();
    a0 = 1'b0; tick();
    b0 = 1'b0; tick();
    tick(2);
  endtask

  task automatic test_reset();
    r0 = 1'b1; a0 = 1'b0; b0 = 1'b0;
    r3 = 1'b1; a3 = 1'b0; b3 = 1'b0;
    tick(5);
    n_tests++;
    if (light0 !== 8'h01) begin
      n_fail++; $display("FAIL reset_light0: got %h expected %h", light0, 8'h01);
    end
    n_tests++;
    if (light3 !== 8'h01) begin
      n_fail++; $display("FAIL reset_light3: got %h expected %h", light3, 8'h01);
    end
    r3 = 1'b0;
    a0 = 1'b1;
    tick(2);
    r0 = 1'b0;
    tick(6);
    n_tests++;
    if (light0 !== 8'h01) begin
      n_fail++; $display("FAIL reset_release_a_high: got %h expected %h", light0, 8'h01);
    end
    a0 = 1'b0;
    tick(4);
    n_tests++;
    if (light0 !== 8'h01) begin
      n_fail++; $display("FAIL reset_a_fall: got %h expected %h", light0, 8'h01);
    end
  endtask

  task automatic test_ccw_latency();
    b0 = 1'b1; tick();
    a0 = 1'b1; tick();
    n_tests++;
    if (light0 !== 8'h01) begin
      n_fail++; $display("FAIL latency_edge1: got %h expected %h", light0, 8'h01);
    end
    b0 = 1'b0; tick();
    n_tests++;
    if (light0 !== 8'h01) begin
      n_fail++; $display("FAIL latency_edge2: got %h expected %h", light0, 8'h01);
    end
    a0 = 1'b0; tick();
    n_tests++;
    if (light0 !== 8'h02) begin
      n_fail++; $display("FAIL latency_edge3: got %h expected %h", light0, 8'h02);
    end
    tick(2);
    n_tests++;
    if (light0 !== 8'h02) begin
      n_fail++; $display("FAIL latency_settle: got %h expected %h", light0, 8'h02);
    end
  endtask

  task automatic test_ccw_wrap();
    logic [7:0] exp_ccw [8];
    exp_ccw = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    for (int i = 0; i < 8; i++) begin
      ccw0();
      n_tests++;
      if (light0 !== exp_ccw[i]) begin
        n_fail++; $display("FAIL ccw_step%0d: got %h expected %h", i + 2, light0, exp_ccw[i]);
      end
    end
  endtask

  task automatic test_cw_wrap();
    logic [7:0] exp_cw [10];
    exp_cw = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    for (int i = 0; i < 10; i++) begin
      cw0();
      n_tests++;
      if (light0 !== exp_cw[i]) begin
        n_fail++; $display("FAIL cw_step%0d: got %h expected %h", i + 1, light0, exp_cw[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    b0 = 1'b1; tick();
    a0 = 1'b1; tick();
    r0 = 1'b1; tick();
    n_tests++;
    if (light0 !== 8'h01) begin
      n_fail++; $display("FAIL mid_reset_light: got %h expected %h", light0, 8'h01);
    end
    r0 = 1'b0;
    b0 = 1'b0; tick();
    a0 = 1'b0; tick();
    tick(4);
    n_tests++;
    if (light0 !== 8'h01) begin
      n_fail++; $display("FAIL mid_reset_no_step: got %h expected %h", light0, 8'h01);
    end
    cw0();
    n_tests++;
    if (light0 !== 8'h80) begin
      n_fail++; $display("FAIL mid_reset_resume: got %h expected %h", light0, 8'h80);
    end
  endtask

  task automatic test_filter_glitch();
    a3 = 1'b1; tick();
    a3 = 1'b0; tick(10);
    n_tests++;
    if (light3 !== 8'h01) begin
      n_fail++; $display("FAIL filter_glitch1: got %h expected %h", light3, 8'h01);
    end
    a3 = 1'b1; tick(2);
    a3 = 1'b0; tick(10);
    n_tests++;
    if (light3 !== 8'h01) begin
      n_fail++; $display("FAIL filter_glitch2: got %h expected %h", light3, 8'h01);
    end
  endtask

  task automatic test_filter_detent();
    b3 = 1'b1; tick(5);
    a3 = 1'b1; tick(5);
    n_tests++;
    if (light3 !== 8'h01) begin
      n_fail++; $display("FAIL filter_latency_edge5: got %h expected %h", light3, 8'h01);
    end
    b3 = 1'b0; tick();
    n_tests++;
    if (light3 !== 8'h02) begin
      n_fail++; $display("FAIL filter_latency_edge6: got %h expected %h", light3, 8'h02);
    end
    tick(4);
    a3 = 1'b0; tick(5);
    tick(10);
    n_tests++;
    if (light3 !== 8'h02) begin
      n_fail++; $display("FAIL filter_ccw_settle: got %h expected %h", light3, 8'h02);
    end
    a3 = 1'b1; tick(5);
    b3 = 1'b1; tick(5);
    a3 = 1'b0; tick(5);
    b3 = 1'b0; tick(5);
    tick(10);
    n_tests++;
    if (light3 !== 8'h01) begin
      n_fail++; $display("FAIL filter_cw: got %h expected %h", light3, 8'h01);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    r0 = 1'b1; a0 = 1'b0; b0 = 1'b0;
    r3 = 1'b1; a3 = 1'b0; b3 = 1'b0;
    test_reset();
    test_ccw_latency();
    test_ccw_wrap();
    test_cw_wrap();
    test_reset_mid();
    test_filter_glitch();
    test_filter_detent();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
